// File: rtl/sequence_store.sv
// Simon Says sequence store: a 32-entry colour memory filled from a free-running
// LFSR, with a timed playback FSM that drives a one-hot LED output.
module sequence_store #(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       append,
  input  logic       play_start,
  output logic [2:0] segment [0:31],
  output logic [5:0] length,
  output logic       full,
  output logic       busy,
  output logic [3:0] led,
  output logic       play_done
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]  EMPTY = 3'b100;
  localparam logic [15:0] TAPS  = 16'hB400;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       len_q, len_d;
  logic [2:0]       seg_q [0:31];
  logic [2:0]       seg_d [0:31];
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       led_q, led_d;
  logic             done_q, done_d;
  logic             full_w;
  logic             append_ok;

  function automatic logic [3:0] decode(input logic [2:0] e);
    decode = e[2] ? 4'b0000 : (4'b0001 << e[1:0]);
  endfunction

  assign full_w    = (len_q == 6'd32);
  assign append_ok = append && (state_q == IDLE) && !full_w && !clear;

  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    seg_d   = seg_q;
    len_d   = len_q;
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;

    if (clear) begin
      for (int unsigned i = 0; i < 32; i++) seg_d[i] = EMPTY;
      len_d   = '0;
      state_d = IDLE;
      p_d     = '0;
      cnt_d   = '0;
    end else begin
      if (append_ok) begin
        seg_d[len_q[4:0]] = {1'b0, lfsr_q[1:0]};
        len_d             = len_q + 6'd1;
      end
      // Playback start looks at len_d so a same-cycle append is included.
      case (state_q)
        IDLE: begin
          if (play_start) begin
            if (len_d != '0) begin
              state_d = SHOW;
              p_d     = '0;
              cnt_d   = HOLD_LOAD;
            end else begin
              state_d = DONE;
            end
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            if (({1'b0, p_q} + 6'd1) == len_q) begin
              state_d = DONE;
            end else begin
              state_d = SHOW;
              p_d     = p_q + 5'd1;
              cnt_d   = HOLD_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from next-state values so they align with state_q.
    led_d  = (state_d == SHOW) ? decode(seg_d[p_d]) : 4'b0000;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q  <= LFSR_SEED;
      for (int unsigned i = 0; i < 32; i++) seg_q[i] <= EMPTY;
      len_q   <= '0;
      state_q <= IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign segment   = seg_q;
  assign length    = len_q;
  assign full      = full_w;
  assign busy      = (state_q != IDLE);
  assign led       = led_q;
  assign play_done = done_q;

endmodule

// File: doc/sequence_store.md
# sequence_store

Holds the Simon Says colour sequence and plays it back to the LEDs. Each round the game controller appends one pseudo-random colour, then requests a playback; the store presents all 32 entries as the `segment` array, which the input checker compares against player presses. Cleared entries read as empty (bit 2 set), so the checker can detect end-of-sequence.

## Interface
- `HOLD_CYCLES`, default 25_000_000: cycles each colour is lit during playback (≥1).
- `GAP_CYCLES`, default 12_500_000: dark cycles after each colour (≥1).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value (must be non-zero).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: start a new game (empty the store).
- `append` in 1: add one random colour.
- `play_start` in 1: begin playback of the stored sequence.
- `segment` out [2:0] x32: entry array, 3'b0cc = colour cc, 3'b100 = empty.
- `length` out 6: number of valid entries, 0..32.
- `full` out 1: `length == 32`.
- `busy` out 1: playback in progress.
- `led` out 4: one-hot colour during playback, else 0.
- `play_done` out 1: one-cycle pulse when playback finishes.

## Operation
- Colour encoding, matching the checker: 3 -> `led` 4'b1000, 2 -> 4'b0100, 1 -> 4'b0010, 0 -> 4'b0001.
- **LFSR:** 16-bit Galois, taps mask 16'hB400. It shifts every cycle regardless of state, so player timing adds entropy. The new colour is `lfsr[1:0]` sampled in the cycle `append` is accepted.
- **Append:** accepted only when `!busy && !full && !clear`.
  - Writes `segment[length] <= {1'b0, lfsr[1:0]}` and `length <= length+1`.
  - Ignored otherwise, with no state change.
- **Clear:**
  - Sets all 32 entries to 3'b100 and `length` to 0.
  - Aborts any playback: FSM goes to IDLE, `led` 0, `busy` 0, no `play_done`.
  - Does not touch the LFSR.
- **Priority:** `reset` > `clear` > (`append`, `play_start`).
- **FSM** states IDLE, SHOW, GAP, DONE; index `p` (5 bit) and down-counter `cnt`:
  - IDLE + `play_start` + `length > 0`: go to SHOW, `p = 0`, `cnt = HOLD_CYCLES-1`.
  - IDLE + `play_start` + `length == 0`: go to DONE.
  - SHOW: `led` = decode(`segment[p]`). When `cnt == 0`, go to GAP with `cnt = GAP_CYCLES-1`, else decrement.
  - GAP: `led` = 0. When `cnt == 0`: if `p+1 == length`, go to DONE; else `p++`, go to SHOW with `cnt = HOLD_CYCLES-1`.
  - DONE: `play_done` = 1 for this single cycle, then IDLE.
- `play_start` outside IDLE is ignored.
- `append` and `play_start` in the same IDLE cycle: both are accepted, and playback covers the new entry. Termination compares against the updated `length`.
- `busy` = state ∈ {SHOW, GAP, DONE}.
- `led` and `play_done` are registered outputs.

## Timing
- **Reset values:**
  - all `segment` = 3'b100, `length` 0, `full` 0, `busy` 0, `led` 0, `play_done` 0
  - FSM IDLE, LFSR = `LFSR_SEED`
- **Append latency:** the entry and `length` are visible in the cycle after `append` is sampled. `full` follows `length` in the same cycle.
- **Playback:**
  - `play_start` sampled at edge T: `busy` = 1 and `led` shows entry 0 from T+1 for exactly `HOLD_CYCLES` cycles, then 0 for `GAP_CYCLES`.
  - Total busy duration is `length*(HOLD_CYCLES+GAP_CYCLES)+1` cycles.
  - `play_done` is high in the last busy cycle.
- **Empty playback:** `play_start` at T gives `busy` = 1 and `play_done` = 1 at T+1 only.
- **Clear or reset mid-playback:** outputs reach reset values at the next edge, with no further `led` activity.
- **Full boundary:** when `length` = 32, `append` is a no-op and `length` does not wrap to 0.

## Test plan
1. **Reset and append:** assert `reset`, then `append` once.
   - After reset: `segment` all 3'b100, `length` 0.
   - One cycle after the append: `length` 1, `segment[0][2]` = 0, `segment[0][1:0]` equals the golden-model LFSR bits.
2. **Playback:** `HOLD_CYCLES`=4, `GAP_CYCLES`=2, three appends, then `play_start`.
   - `led` follows (4 lit, 2 dark) ×3 with the correct one-hot per entry.
   - `play_done` pulses at cycle 19, `busy` is high for 19 cycles.
3. **Empty playback:** `play_start` with `length` 0 -> `play_done` and `busy` high for exactly 1 cycle, `led` stays 0.
4. **Fill and overflow:** 33 appends -> `length` 32, `full` 1, 33rd append changes nothing.
   - Then `clear` -> `length` 0, `full` 0, all entries 3'b100.
5. **Abort:** `clear` asserted mid-SHOW of entry 1 -> next cycle `led` 0, `busy` 0, no `play_done`. A following `play_start` gives immediate empty playback.
6. **Ignored and simultaneous requests:**
   - `append` while `busy` -> ignored, `length` unchanged.
   - `append` and `play_start` together with `length` 2 -> `length` 3 and three colours played.
